csa_resolver: RTL and testbench

Carry-propagate back end for the SHA-256 carry-save datapath. It accepts a redundant (sum, carry) vector pair produced by the 4:2 compressor tree and resolves it to a binary word, (sum + carry) mod 2^WIDTH. The block is a two-stage pipelined split adder with valid/ready handshakes on both sides. It sits between the compressor tree output and the working-variable registers (A/E update) of the round logic.

---
 rtl/csa_resolver.sv | 134 +++++++++++++
 tb/tb_csa_resolver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : csa_resolver
//  Purpose  : Carry-propagate back end for the SHA-256 carry-save datapath.
//             Resolves a redundant (sum, carry) pair into the binary word
//             (sum + carry) mod 2^WIDTH. It uses a two-stage split adder with
//             valid/ready handshakes on both sides.
//  Options  : CSA_RESOLVER_COUT_EN - adds the out_cout port, which carries
//             the carry out of bit WIDTH-1.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_resolver #(
   parameter int WIDTH = 32,
   parameter int LO_W  = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef CSA_RESOLVER_COUT_EN
   ,
   output logic             out_cout
`endif
);

   localparam int HI_W = WIDTH - LO_W;

   // Stage 1: resolved low half, its carry, and raw high halves.
   logic              r_v1;
   logic [LO_W-1:0]   r_lo;
   logic              r_c_mid;
   logic [HI_W-1:0]   r_hi_sum;
   logic [HI_W-1:0]   r_hi_carry;

   // Stage 2: the fully resolved word presented to the consumer.
   logic              r_v2;
   logic [WIDTH-1:0]  r_data;

   logic              w_adv2;
   logic              w_acc1;
   logic [LO_W:0]     w_lo_ext;
   logic [HI_W-1:0]   w_hi;
`ifdef CSA_RESOLVER_COUT_EN
   logic              w_cout;
   logic              r_cout;
`endif

   // Stage 2 refills whenever it is empty or is being drained this cycle.
   // Stage 1 takes a new pair whenever its contents move on or it is empty.
   always_comb begin
      w_adv2 = r_v1 && (!r_v2 || out_ready);
      w_acc1 = in_valid && (!r_v1 || w_adv2);
   end

   // Ready depends only on pipeline occupancy and out_ready, never on in_valid.
   assign in_ready = !r_v1 || !r_v2 || out_ready;

   // Low-half add. The extra bit is the carry that crosses into the high half.
   always_comb begin
      w_lo_ext = {1'b0, in_sum[LO_W-1:0]} + {1'b0, in_carry[LO_W-1:0]};
   end

`ifdef CSA_RESOLVER_COUT_EN
   // High-half add, including the split carry. The top bit is kept as cout.
   always_comb begin
      {w_cout, w_hi} = {1'b0, r_hi_sum} + {1'b0, r_hi_carry}
                     + {{HI_W{1'b0}}, r_c_mid};
   end
`else
   // High-half add, including the split carry. The carry out is dropped.
   always_comb begin
      w_hi = r_hi_sum + r_hi_carry + {{(HI_W-1){1'b0}}, r_c_mid};
   end
`endif

   // Stage 1 register. It captures on accept and empties when its word moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1       <= 1'b0;
         r_lo       <= '0;
         r_c_mid    <= 1'b0;
         r_hi_sum   <= '0;
         r_hi_carry <= '0;
      end else begin
         if (w_acc1) begin
            r_v1       <= 1'b1;
            r_lo       <= w_lo_ext[LO_W-1:0];
            r_c_mid    <= w_lo_ext[LO_W];
            r_hi_sum   <= in_sum[WIDTH-1:LO_W];
            r_hi_carry <= in_carry[WIDTH-1:LO_W];
         end else if (w_adv2) begin
            r_v1 <= 1'b0;
         end
      end
   end

   // Stage 2 register. Data holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_data <= '0;
      end else begin
         if (w_adv2) begin
            r_v2   <= 1'b1;
            r_data <= {w_hi, r_lo};
         end else if (out_ready) begin
            r_v2 <= 1'b0;
         end
      end
   end

`ifdef CSA_RESOLVER_COUT_EN
   // Carry out travels with out_data under the same load and hold rules.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cout <= 1'b0;
      end else if (w_adv2) begin
         r_cout <= w_cout;
      end
   end

   assign out_cout = r_cout;
`endif

   assign out_valid = r_v2;
   assign out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_csa_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_resolver
//  Purpose  : Self-checking bench for csa_resolver. It uses a queue-based
//             reference model of accepted words and their arithmetic sums.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_resolver;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef CSA_RESOLVER_COUT_EN
   logic             out_cout;
`endif

   csa_resolver #(.WIDTH(WIDTH), .LO_W(WIDTH/2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef CSA_RESOLVER_COUT_EN
      ,
      .out_cout  (out_cout)
`endif
   );

   // Free-running clock with a period of 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each accepted word carries its full-width arithmetic sum
   // and the index of the edge that accepted it.
   typedef struct {
      logic [WIDTH:0] sum;
      int             acc_edge;
   } item_t;

   item_t       q[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_in = 0;
   int          n_out = 0;
   logic        hold_prev = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Count rising edges so acceptance times can be compared with the present.
   always @(posedge clk) cyc <= cyc + 1;

   // Compare process. Sampling at the falling edge sees exactly the values that
   // the next rising edge will act on.
   always @(negedge clk) begin
      logic exp_v;
      if (rst_n === 1'b1) begin
         // Only two words fit. A full pipe accepts only while draining.
         chk("in_ready", in_ready, (q.size() < 2) || out_ready);
         // The oldest word is visible once one edge has passed after its accept edge.
         exp_v = 1'b0;
         if (q.size() > 0) exp_v = (cyc >= q[0].acc_edge + 1);
         chk("out_valid", out_valid, exp_v);
         if (out_valid && q.size() > 0) begin
            chk("out_data", out_data, q[0].sum[WIDTH-1:0]);
`ifdef CSA_RESOLVER_COUT_EN
            chk("out_cout", out_cout, q[0].sum[WIDTH]);
`endif
         end
         if (hold_prev) chk("hold_stable", out_data, prev_data);
         hold_prev = out_valid && !out_ready;
         prev_data = out_data;
         if (out_valid && out_ready) begin
            if (q.size() > 0) void'(q.pop_front());
            n_out++;
         end
         if (in_valid && in_ready) begin
            q.push_back('{sum: {1'b0, in_sum} + {1'b0, in_carry}, acc_edge: cyc + 1});
            n_in++;
         end
      end
   end

   // One isolated transfer with out_ready high, checked against literal values.
   task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_d, input logic exp_c);
      in_valid = 1'b1;
      in_sum   = a;
      in_carry = b;
      @(negedge clk);
      chk("dir_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("dir_latency_early", out_valid, 0);
      @(negedge clk);
      chk("dir_out_valid", out_valid, 1);
      chk("dir_out_data", out_data, exp_d);
`ifdef CSA_RESOLVER_COUT_EN
      chk("dir_out_cout", out_cout, exp_c);
`else
      if (exp_c === 1'bx) chk("dir_unused", 0, 1);
`endif
      @(posedge clk); #1;
   endtask

   // Stop the run if the stimulus ever stalls forever.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] bs [4];
      logic [WIDTH-1:0] bc [4];
      int idx;
      logic acc;
      int start_in, start_out, guard;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      out_ready = 1'b0;

      // Reset state.
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
`ifdef CSA_RESOLVER_COUT_EN
      chk("rst_out_cout", out_cout, 0);
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      // Directed arithmetic cases.
      out_ready = 1'b1;
      run_one(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0);
      run_one(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0);
      run_one(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
      run_one(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
      run_one(32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
      run_one(32'h7FFF_FFFF, 32'h0000_8001, 32'h8000_8000, 1'b0);

      // Backpressure: four words with the consumer stalled, then released.
      bs[0] = 32'h0000_FFFF; bc[0] = 32'h0000_0001;
      bs[1] = 32'hA5A5_A5A5; bc[1] = 32'h5A5A_5A5B;
      bs[2] = 32'h0123_4567; bc[2] = 32'h89AB_CDEF;
      bs[3] = 32'hFFFF_0000; bc[3] = 32'h0001_0000;
      out_ready = 1'b0;
      idx = 0;
      in_valid = 1'b1; in_sum = bs[0]; in_carry = bc[0];
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin in_sum = bs[idx]; in_carry = bc[idx]; end
            else in_valid = 1'b0;
         end
      end
      chk("bp_accepts", idx, 2);
      chk("bp_stall", in_ready, 0);
      chk("bp_held_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_flow", out_valid, 1);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin in_sum = bs[idx]; in_carry = bc[idx]; end
            else in_valid = 1'b0;
         end
      end
      chk("bp_all_sent", idx, 4);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Random streaming with random valid and ready.
      start_in  = n_in;
      start_out = n_out;
      guard     = 0;
      while ((n_in - start_in) < 10000 && guard < 60000) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 70);
         case ($urandom_range(0, 7))
            0:       begin in_sum = '1;        in_carry = $urandom; end
            1:       begin in_sum = $urandom;  in_carry = ~in_sum + 32'(($urandom_range(0, 2))); end
            2:       begin in_sum = 32'h0000_FFFF & $urandom; in_carry = 32'h0000_FFFF; end
            default: begin in_sum = $urandom;  in_carry = $urandom; end
         endcase
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      chk("rand_sent", n_in - start_in, 10000);
      out_ready = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("rand_drained", q.size(), 0);
      chk("rand_count", n_out - start_out, n_in - start_in);

      // Asynchronous reset with both stages full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sum    = 32'hDEAD_BEEF;
      in_carry  = 32'h1111_1111;
      guard = 0;
      start_in = n_in;
      while ((n_in - start_in) < 2 && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_full_valid", out_valid, 1);
      chk("pre_rst_full_ready", in_ready, 0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
`ifdef CSA_RESOLVER_COUT_EN
      chk("async_rst_cout", out_cout, 0);
`endif
      q.delete();
      hold_prev = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_no_stale", out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
